// File: rtl/parity_rx.sv
// Serial frame receiver: start bit, N data bits LSB first,
// even parity bit, stop bit; one bit per bit_en strobe.
module parity_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_en,
  input  logic         sin,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shift;
  logic          p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      p          <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (bit_en) begin
        unique case (state)
          IDLE: begin
            if (!sin) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shift[cnt] <= sin;
            if (cnt == LAST) begin
              state <= PARITY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            p     <= sin;
            state <= STOP;
          end
          STOP: begin
            // frame done: publish even on a bad stop bit
            state      <= IDLE;
            busy       <= 1'b0;
            data       <= shift;
            valid      <= 1'b1;
            parity_err <= (^shift) ^ p;
            frame_err  <= ~sin;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx (N=4): frames, gaps,
// mid-frame reset and back-to-back reception.
module tb_parity_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_en;
  logic       sin;
  logic [3:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int vcount     = 0;
  int last_pulse = 0;
  int prev_pulse = 0;
  int v0;

  parity_rx #(.N(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .sin        (sin),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid === 1'b1) begin
      vcount     <= vcount + 1;
      prev_pulse <= last_pulse;
      last_pulse <= cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    sin    = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap,
                        input logic gbusy,
                        input logic ebusy,
                        input logic evalid,
                        input string tag);
    for (int g = 0; g < gap; g++) begin
      bit_en = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " gap busy"}, 32'(busy), 32'(gbusy));
      chk({tag, " gap valid"}, 32'(valid), 32'd0);
    end
    bit_en = 1'b1;
    sin    = b;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    sin    = 1'b1;
    chk({tag, " busy"}, 32'(busy), 32'(ebusy));
    chk({tag, " valid"}, 32'(valid), 32'(evalid));
  endtask

  task automatic frame(input logic [3:0] d,
                       input logic pb,
                       input logic st,
                       input int gap,
                       input string tag);
    logic [6:0] bits;
    bits = {st, pb, d, 1'b0};
    for (int i = 0; i < 7; i++)
      strobe(bits[i], gap, i != 0, i != 6, i == 6, tag);
  endtask

  task automatic outs(input string tag,
                      input logic [3:0] ed,
                      input logic ep,
                      input logic ef);
    chk({tag, " data"}, 32'(data), 32'(ed));
    chk({tag, " parity_err"}, 32'(parity_err), 32'(ep));
    chk({tag, " frame_err"}, 32'(frame_err), 32'(ef));
  endtask

  initial begin
    reset  = 1'b1;
    bit_en = 1'b0;
    sin    = 1'b1;
    #2;
    outs("reset", 4'b0000, 1'b0, 1'b0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    strobe(1'b1, 0, 1'b0, 1'b0, 1'b0, "idle high");

    v0 = vcount;
    frame(4'b1011, 1'b1, 1'b1, 0, "good");
    outs("good", 4'b1011, 1'b0, 1'b0);
    idle(2);
    chk("good after valid", 32'(valid), 32'd0);
    chk("good pulses", 32'(vcount - v0), 32'd1);

    frame(4'b1011, 1'b0, 1'b1, 0, "badpar");
    outs("badpar", 4'b1011, 1'b1, 1'b0);
    idle(3);
    outs("badpar hold", 4'b1011, 1'b1, 1'b0);

    frame(4'b0000, 1'b0, 1'b0, 0, "zeros");
    outs("zeros", 4'b0000, 1'b0, 1'b1);
    idle(2);

    v0 = vcount;
    frame(4'b0110, 1'b0, 1'b1, 2, "gaps");
    outs("gaps", 4'b0110, 1'b0, 1'b0);
    idle(2);
    chk("gaps pulses", 32'(vcount - v0), 32'd1);

    frame(4'b1011, 1'b1, 1'b1, 0, "preload");
    idle(2);
    v0 = vcount;
    strobe(1'b0, 0, 1'b0, 1'b1, 1'b0, "abort s");
    strobe(1'b1, 0, 1'b1, 1'b1, 1'b0, "abort d0");
    strobe(1'b1, 0, 1'b1, 1'b1, 1'b0, "abort d1");
    reset = 1'b1;
    #1;
    chk("async busy", 32'(busy), 32'd0);
    outs("async", 4'b0000, 1'b0, 1'b0);
    bit_en = 1'b1;
    sin    = 1'b0;
    @(posedge clk);
    #1;
    chk("held busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(1);
    strobe(1'b1, 0, 1'b0, 1'b0, 1'b0, "post rst");
    chk("abort pulses", 32'(vcount - v0), 32'd0);
    frame(4'b1011, 1'b1, 1'b1, 0, "recover");
    outs("recover", 4'b1011, 1'b0, 1'b0);
    idle(2);
    chk("recover pulses", 32'(vcount - v0), 32'd1);

    v0 = vcount;
    frame(4'b1011, 1'b1, 1'b1, 0, "b2b a");
    frame(4'b0001, 1'b1, 1'b1, 0, "b2b b");
    outs("b2b", 4'b0001, 1'b0, 1'b0);
    idle(2);
    chk("b2b pulses", 32'(vcount - v0), 32'd2);
    chk("b2b spacing", 32'(last_pulse - prev_pulse), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
